// File: rtl/button_debouncer_if.sv
// Pin-side bundle for the two-channel button debouncer: raw buttons in, clean levels and strobes out.
interface button_debouncer_if;
  logic i_left_raw;
  logic i_right_raw;
  logic o_left_debounced;
  logic o_right_debounced;
  logic o_left_press;
  logic o_right_press;
  logic o_left_release;
  logic o_right_release;

  modport master (
    output i_left_raw, i_right_raw,
    input  o_left_debounced, o_right_debounced,
    input  o_left_press, o_right_press,
    input  o_left_release, o_right_release
  );

  modport slave (
    input  i_left_raw, i_right_raw,
    output o_left_debounced, o_right_debounced,
    output o_left_press, o_right_press,
    output o_left_release, o_right_release
  );
endinterface

// File: rtl/button_debouncer.sv
// Two independent synchronise-and-debounce channels (0 = left, 1 = right) with press/release strobes.
// Optional AUTOREPEAT_EN adds periodic press strobes while a button stays held.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SYNC_STAGES     = 2,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic               i_clk_25MHz,
  input  logic               i_reset_n,
  button_debouncer_if.slave  bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DELAY_M1  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PERIOD_M1 = REP_W'(REPEAT_PERIOD - 1);
  localparam logic [REP_W-1:0] REP_ONE       = REP_W'(1);
`endif

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  logic [1:0] w_raw;
  logic [1:0] w_level;
  logic [1:0] w_press;
  logic [1:0] w_release;

  assign w_raw = {bus.i_right_raw, bus.i_left_raw};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic [SYNC_STAGES-1:0] r_sync;
      logic                   w_s;
      state_t                 r_state;
      logic [CNT_W-1:0]       r_cnt;
      logic                   r_level;
      logic                   r_press;
      logic                   r_release;
`ifdef AUTOREPEAT_EN
      logic [REP_W-1:0]       r_rep_cnt;
      logic                   r_rep_first;
`endif

      assign w_s = r_sync[SYNC_STAGES-1];

      always_ff @(posedge i_clk_25MHz or negedge i_reset_n) begin
        if (!i_reset_n) begin
          r_sync <= '0;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[gi]};
        end
      end

      always_ff @(posedge i_clk_25MHz or negedge i_reset_n) begin
        if (!i_reset_n) begin
          r_state     <= IDLE;
          r_cnt       <= '0;
          r_level     <= 1'b0;
          r_press     <= 1'b0;
          r_release   <= 1'b0;
`ifdef AUTOREPEAT_EN
          r_rep_cnt   <= '0;
          r_rep_first <= 1'b1;
`endif
        end else begin
          r_press   <= 1'b0;
          r_release <= 1'b0;
          case (r_state)
            IDLE: begin
              if (w_s) begin
                r_state <= PRESS_WAIT;
                r_cnt   <= CNT_ONE;
              end
            end
            PRESS_WAIT: begin
              if (!w_s) begin
                r_state <= IDLE;
                r_cnt   <= '0;
              end else if (r_cnt == CNT_MAX) begin
                r_state <= PRESSED;
                r_level <= 1'b1;
                r_press <= 1'b1;
              end else begin
                r_cnt <= r_cnt + CNT_ONE;
              end
            end
            PRESSED: begin
              if (!w_s) begin
                r_state <= RELEASE_WAIT;
                r_cnt   <= CNT_ONE;
              end
`ifdef AUTOREPEAT_EN
              // Repeat time accrues only in PRESSED; first interval is the delay, then the period.
              if (r_rep_cnt == (r_rep_first ? REP_DELAY_M1 : REP_PERIOD_M1)) begin
                r_press     <= 1'b1;
                r_rep_cnt   <= '0;
                r_rep_first <= 1'b0;
              end else begin
                r_rep_cnt <= r_rep_cnt + REP_ONE;
              end
`endif
            end
            RELEASE_WAIT: begin
              if (w_s) begin
                r_state <= PRESSED;
              end else if (r_cnt == CNT_MAX) begin
                r_state   <= IDLE;
                r_cnt     <= '0;
                r_level   <= 1'b0;
                r_release <= 1'b1;
`ifdef AUTOREPEAT_EN
                r_rep_cnt   <= '0;
                r_rep_first <= 1'b1;
`endif
              end else begin
                r_cnt <= r_cnt + CNT_ONE;
              end
            end
            default: begin
              r_state <= IDLE;
              r_cnt   <= '0;
              r_level <= 1'b0;
            end
          endcase
        end
      end

      assign w_level[gi]   = r_level;
      assign w_press[gi]   = r_press;
      assign w_release[gi] = r_release;
    end
  endgenerate

  assign bus.o_left_debounced  = w_level[0];
  assign bus.o_right_debounced = w_level[1];
  assign bus.o_left_press      = w_press[0];
  assign bus.o_right_press     = w_press[1];
  assign bus.o_left_release    = w_release[0];
  assign bus.o_right_release   = w_release[1];

endmodule
